// File: rtl/viterbi_pkg.sv
// Shared definitions for the forward (ACS) half of the 8-state hard-decision
// Viterbi decoder.
//   NUM_STATES : trellis size
//   PRED       : PRED[s][d] is the predecessor of state s selected by decision d
//   EXP        : EXP[s][d] is the {g1,g0} code emitted on transition PRED[s][d] -> s
//                (encoder generators g1 = 1111b, g0 = 1101b, newest bit first)
//   fsm_state_t: FILL / SEARCH / TRACE
//   hamming2   : distance between two 2-bit code pairs
package viterbi_pkg;

   localparam int NUM_STATES = 8;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      SEARCH = 2'd1,
      TRACE  = 2'd2
   } fsm_state_t;

   localparam logic [2:0] PRED [NUM_STATES][2] = '{
      '{3'd0, 3'd1}, '{3'd3, 3'd2}, '{3'd4, 3'd5}, '{3'd7, 3'd6},
      '{3'd1, 3'd0}, '{3'd2, 3'd3}, '{3'd5, 3'd4}, '{3'd6, 3'd7}
   };

   localparam logic [1:0] EXP [NUM_STATES][2] = '{
      '{2'b00, 2'b11}, '{2'b01, 2'b10}, '{2'b11, 2'b00}, '{2'b10, 2'b01},
      '{2'b00, 2'b11}, '{2'b01, 2'b10}, '{2'b11, 2'b00}, '{2'b10, 2'b01}
   };

   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] x;
      x = a ^ b;
      return {1'b0, x[1]} + {1'b0, x[0]};
   endfunction

endpackage

// File: rtl/acs_survivor_writer_if.sv
// Handshake and survivor-memory bus of acs_survivor_writer.
//   master: symbol source / memory + trace-back side (drives in_valid, rx_sym)
//   slave : the ACS block (drives in_ready, memory write port, trace controls)
interface acs_survivor_writer_if #(
   parameter int AW = 6
);
   logic          in_valid;
   logic [1:0]    rx_sym;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_address_write;
   logic [7:0]    write_data;
   logic          trace_enable;
   logic [2:0]    idx_out;
   logic          block_done;

   modport master (
      output in_valid, rx_sym,
      input  in_ready, mem_we, mem_address_write, write_data,
      input  trace_enable, idx_out, block_done
   );

   modport slave (
      input  in_valid, rx_sym,
      output in_ready, mem_we, mem_address_write, write_data,
      output trace_enable, idx_out, block_done
   );
endinterface

// File: rtl/acs_unit.sv
// One add-compare-select cell of the trellis (purely combinational).
//   pm_0, pm_1 : metrics of the two predecessors (decision 0 / 1)
//   bm_0, bm_1 : branch metrics of the two incoming transitions
//   pm_new     : selected, saturated metric
//   dec        : 1 iff the decision-1 path is strictly better
module acs_unit #(
   parameter int PM_W = 8
) (
   input  logic [PM_W-1:0] pm_0,
   input  logic [PM_W-1:0] pm_1,
   input  logic [1:0]      bm_0,
   input  logic [1:0]      bm_1,
   output logic [PM_W-1:0] pm_new,
   output logic            dec
);

   logic [PM_W:0]   sum_0_s;
   logic [PM_W:0]   sum_1_s;
   logic [PM_W-1:0] cand_0_s;
   logic [PM_W-1:0] cand_1_s;

   // Saturating add of both candidates, then select with ties going to branch 0
   always_comb begin
      sum_0_s = {1'b0, pm_0} + {{(PM_W-1){1'b0}}, bm_0};
      sum_1_s = {1'b0, pm_1} + {{(PM_W-1){1'b0}}, bm_1};
      if (sum_0_s[PM_W]) begin
         cand_0_s = {PM_W{1'b1}};
      end else begin
         cand_0_s = sum_0_s[PM_W-1:0];
      end
      if (sum_1_s[PM_W]) begin
         cand_1_s = {PM_W{1'b1}};
      end else begin
         cand_1_s = sum_1_s[PM_W-1:0];
      end
      if (cand_1_s < cand_0_s) begin
         dec    = 1'b1;
         pm_new = cand_1_s;
      end else begin
         dec    = 1'b0;
         pm_new = cand_0_s;
      end
   end

endmodule

// File: rtl/acs_survivor_writer.sv
// Forward half of the Viterbi decoder: runs ACS over the 8-state trellis for
// one block of DEPTH symbols, writes one decision word per symbol to survivor
// memory, finds the minimum-metric end state and hands it to trace-back.
//   clk, rst          : clock, asynchronous active-high reset
//   bus.in_valid/rx_sym/in_ready : symbol handshake (accepted only in FILL)
//   bus.mem_we/mem_address_write/write_data : survivor write port (1-cycle latency)
//   bus.trace_enable/idx_out     : trace-back start, held for DEPTH cycles
//   bus.block_done               : pulse after the last trace_enable cycle
module acs_survivor_writer
   import viterbi_pkg::*;
#(
   parameter int              DEPTH   = 64,
   parameter int              AW      = 6,
   parameter int              PM_W    = 8,
   parameter logic [PM_W-1:0] PM_INIT = 8'd32
) (
   input logic                 clk,
   input logic                 rst,
   acs_survivor_writer_if.slave bus
);

   fsm_state_t      state_r;
   logic [PM_W-1:0] pm_r      [NUM_STATES];
   logic [PM_W-1:0] pm_next_s [NUM_STATES];
   logic [7:0]      dec_s;
   logic [AW-1:0]   sym_cnt_r;
   logic [AW-1:0]   addr_r;
   logic [AW-1:0]   trace_cnt_r;
   logic [2:0]      scan_r;
   logic [2:0]      min_idx_r;
   logic [PM_W-1:0] min_val_r;
   logic [2:0]      idx_r;
   logic            in_ready_r;
   logic            mem_we_r;
   logic            trace_enable_r;
   logic            block_done_r;
   logic [7:0]      write_data_r;
   logic            accept_s;
   logic            scan_take_s;
   logic [2:0]      best_idx_s;

   // in_ready_r is only ever high in FILL, so it doubles as the FILL qualifier
   assign accept_s = in_ready_r & bus.in_valid;

   for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
      acs_unit #(.PM_W(PM_W)) u_acs (
         .pm_0   (pm_r[PRED[s][0]]),
         .pm_1   (pm_r[PRED[s][1]]),
         .bm_0   (hamming2(bus.rx_sym, EXP[s][0])),
         .bm_1   (hamming2(bus.rx_sym, EXP[s][1])),
         .pm_new (pm_next_s[s]),
         .dec    (dec_s[s])
      );
   end

   // Minimum-search step: scan slot 0 always loads, later slots replace on strict less-than
   always_comb begin
      if (scan_r == 3'd0) begin
         scan_take_s = 1'b1;
      end else begin
         scan_take_s = (pm_r[scan_r] < min_val_r);
      end
      if (scan_take_s) begin
         best_idx_s = scan_r;
      end else begin
         best_idx_s = min_idx_r;
      end
   end

   // Block FSM with metrics, write port and trace-back controls as registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= FILL;
         for (int i = 0; i < NUM_STATES; i++) begin
            pm_r[i] <= (i == 0) ? {PM_W{1'b0}} : PM_INIT;
         end
         sym_cnt_r      <= {AW{1'b0}};
         addr_r         <= {AW{1'b0}};
         trace_cnt_r    <= {AW{1'b0}};
         scan_r         <= 3'd0;
         min_idx_r      <= 3'd0;
         min_val_r      <= {PM_W{1'b0}};
         idx_r          <= 3'd0;
         in_ready_r     <= 1'b0;
         mem_we_r       <= 1'b0;
         trace_enable_r <= 1'b0;
         block_done_r   <= 1'b0;
         write_data_r   <= 8'd0;
      end else begin
         mem_we_r     <= accept_s;
         block_done_r <= 1'b0;
         // address advances once the pending write has been presented
         if (mem_we_r) begin
            addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            addr_r <= addr_r;
         end
         case (state_r)
            FILL: begin
               if (accept_s) begin
                  for (int i = 0; i < NUM_STATES; i++) begin
                     pm_r[i] <= pm_next_s[i];
                  end
                  write_data_r <= dec_s;
                  sym_cnt_r    <= sym_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                  if (sym_cnt_r == AW'(DEPTH - 1)) begin
                     state_r    <= SEARCH;
                     in_ready_r <= 1'b0;
                     scan_r     <= 3'd0;
                  end else begin
                     in_ready_r <= 1'b1;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            SEARCH: begin
               if (scan_take_s) begin
                  min_val_r <= pm_r[scan_r];
                  min_idx_r <= scan_r;
               end else begin
                  min_val_r <= min_val_r;
               end
               scan_r <= scan_r + 3'd1;
               if (scan_r == 3'd7) begin
                  idx_r          <= best_idx_s;
                  state_r        <= TRACE;
                  trace_enable_r <= 1'b1;
                  trace_cnt_r    <= {AW{1'b0}};
               end else begin
                  trace_enable_r <= 1'b0;
               end
            end
            TRACE: begin
               trace_cnt_r <= trace_cnt_r + {{(AW-1){1'b0}}, 1'b1};
               if (trace_cnt_r == AW'(DEPTH - 1)) begin
                  state_r        <= FILL;
                  trace_enable_r <= 1'b0;
                  block_done_r   <= 1'b1;
                  in_ready_r     <= 1'b1;
                  for (int i = 0; i < NUM_STATES; i++) begin
                     pm_r[i] <= (i == 0) ? {PM_W{1'b0}} : PM_INIT;
                  end
               end else begin
                  trace_enable_r <= 1'b1;
               end
            end
            default: begin
               state_r        <= FILL;
               in_ready_r     <= 1'b0;
               trace_enable_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready          = in_ready_r;
   assign bus.mem_we            = mem_we_r;
   assign bus.mem_address_write = addr_r;
   assign bus.write_data        = write_data_r;
   assign bus.trace_enable      = trace_enable_r;
   assign bus.idx_out           = idx_r;
   assign bus.block_done        = block_done_r;

endmodule

// File: tb/tb_acs_survivor_writer.sv
// Self-checking bench for acs_survivor_writer: directed and random blocks
// compared against a trellis model built from the encoder definition.
module tb_acs_survivor_writer;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   acs_survivor_writer_if #(.AW(AW)) bus ();

   acs_survivor_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [1:0] sym_a [DEPTH];
   int         pm_m  [8];
   logic [7:0] dec_m [DEPTH];
   int         idx_m;

   // monitor state
   logic [AW-1:0] wr_addr_q [$];
   logic [7:0]    wr_data_q [$];
   int cyc = 0, last_wr_cyc = 0, first_te_cyc = 0;
   int te_cycles = 0, done_pulses = 0, idx_changes = 0, ready_in_trace = 0;
   logic [2:0] te_idx = 3'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ham(input int a, input int b);
      int x;
      x = (a ^ b) & 3;
      return (x & 1) + (x >> 1);
   endfunction

   // code pair emitted when entering s from p: register = {new bit, p[2:0]}
   function automatic int enc(input int s, input int p);
      int r, g1, g0;
      r  = (((s >> 2) & 1) << 3) | p;
      g1 = $countones(r & 15) & 1;
      g0 = $countones(r & 13) & 1;
      return (g1 << 1) | g0;
   endfunction

   // the two states that shift into s, ordered by decision bit
   function automatic int pred(input int s, input int d);
      return ((s << 1) & 6) | (d ^ (s & 1) ^ ((s >> 2) & 1));
   endfunction

   task automatic model_block();
      int nxt [8];
      int c   [2];
      pm_m[0] = 0;
      for (int i = 1; i < 8; i++) pm_m[i] = 32;
      for (int t = 0; t < DEPTH; t++) begin
         dec_m[t] = 8'd0;
         for (int s = 0; s < 8; s++) begin
            for (int d = 0; d < 2; d++) begin
               c[d] = pm_m[pred(s, d)] + ham(int'(sym_a[t]), enc(s, pred(s, d)));
               if (c[d] > 255) c[d] = 255;
            end
            if (c[1] < c[0]) begin
               nxt[s] = c[1];
               dec_m[t][s] = 1'b1;
            end else begin
               nxt[s] = c[0];
            end
         end
         for (int s = 0; s < 8; s++) pm_m[s] = nxt[s];
      end
      idx_m = 0;
      for (int s = 1; s < 8; s++) if (pm_m[s] < pm_m[idx_m]) idx_m = s;
   endtask

   // Sample DUT outputs on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         cyc++;
         if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_address_write);
            wr_data_q.push_back(bus.write_data);
            last_wr_cyc = cyc;
         end
         if (bus.trace_enable === 1'b1) begin
            if (te_cycles == 0) begin
               first_te_cyc = cyc;
               te_idx = bus.idx_out;
            end else if (bus.idx_out !== te_idx) begin
               idx_changes++;
            end
            te_cycles++;
            if (bus.in_ready !== 1'b0) ready_in_trace++;
         end
         if (bus.block_done === 1'b1) done_pulses++;
      end
   end

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      te_cycles = 0;
      done_pulses = 0;
      idx_changes = 0;
      ready_in_trace = 0;
   endtask

   // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps
   task automatic send_block(input int gap_mode);
      for (int i = 0; i < DEPTH; i++) begin
         int guard = 0;
         while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 100) check("ready_timeout", 32'd0, 32'd1);
         bus.in_valid = 1'b1;
         bus.rx_sym   = sym_a[i];
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         bus.rx_sym   = 2'($urandom_range(0, 3));
         if (gap_mode == 1) begin
            @(posedge clk); #1;
         end else if (gap_mode == 2) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end
   endtask

   // garbage offered during SEARCH/TRACE must be ignored
   task automatic wait_done();
      int guard = 0;
      bus.in_valid = 1'b1;
      while (bus.block_done !== 1'b1 && guard < 300) begin
         bus.rx_sym = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         guard++;
      end
      bus.in_valid = 1'b0;
      if (guard >= 300) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_block(input string tag);
      int n;
      n = wr_addr_q.size();
      check({tag, "_nwrites"}, 32'(n), 32'(DEPTH));
      for (int i = 0; i < DEPTH && i < n; i++) begin
         check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
         check({tag, "_data"}, 32'(wr_data_q[i]), 32'(dec_m[i]));
      end
      check({tag, "_idx_out"}, 32'(bus.idx_out), 32'(idx_m));
      check({tag, "_te_idx"}, 32'(te_idx), 32'(idx_m));
      check({tag, "_te_cycles"}, 32'(te_cycles), 32'(DEPTH));
      check({tag, "_search_len"}, 32'(first_te_cyc - last_wr_cyc), 32'd8);
      check({tag, "_idx_stable"}, 32'(idx_changes), 32'd0);
      check({tag, "_ready_in_trace"}, 32'(ready_in_trace), 32'd0);
      check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic full_block(input string tag, input int gap_mode);
      model_block();
      clear_mon();
      send_block(gap_mode);
      wait_done();
      @(posedge clk); #1;
      check_block(tag);
   endtask

   initial begin
      int guard;
      bus.in_valid = 1'b0;
      bus.rx_sym   = 2'b00;

      // reset only
      #1 rst = 1'b1;
      #20;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_addr", 32'(bus.mem_address_write), 32'd0);
      check("rst_wdata", 32'(bus.write_data), 32'd0);
      check("rst_trace_en", 32'(bus.trace_enable), 32'd0);
      check("rst_idx", 32'(bus.idx_out), 32'd0);
      check("rst_done", 32'(bus.block_done), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("post_rst_no_write", 32'(wr_addr_q.size()), 32'd0);
      check("post_rst_addr", 32'(bus.mem_address_write), 32'd0);

      // all-zero block, back-to-back
      for (int i = 0; i < DEPTH; i++) sym_a[i] = 2'b00;
      full_block("zero", 0);

      // all-zero block, in_valid every other cycle
      full_block("zero_gap", 1);

      // single 01 at symbol 10
      sym_a[10] = 2'b01;
      full_block("sym10", 0);
      check("sym10_pm0", 32'(pm_m[0]), 32'd1);
      sym_a[10] = 2'b00;

      // reset pulse during TRACE cycle 20
      model_block();
      clear_mon();
      send_block(0);
      guard = 0;
      while (te_cycles < 20 && guard < 200) begin @(posedge clk); #1; guard++; end
      if (guard >= 200) check("trace_wait_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_trace_en", 32'(bus.trace_enable), 32'd0);
      check("midrst_idx", 32'(bus.idx_out), 32'd0);
      check("midrst_addr", 32'(bus.mem_address_write), 32'd0);
      check("midrst_done", 32'(bus.block_done), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      full_block("after_rst", 0);

      // two back-to-back random blocks, then a random block with random gaps
      for (int i = 0; i < DEPTH; i++) sym_a[i] = 2'($urandom_range(0, 3));
      full_block("rand_a", 0);
      for (int i = 0; i < DEPTH; i++) sym_a[i] = 2'($urandom_range(0, 3));
      full_block("rand_b", 0);
      for (int i = 0; i < DEPTH; i++) sym_a[i] = 2'($urandom_range(0, 3));
      full_block("rand_gap", 2);

      // second zero block after random traffic: no stale metrics
      for (int i = 0; i < DEPTH; i++) sym_a[i] = 2'b00;
      full_block("zero_again", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
